// File: rtl/ball_engine_if.sv
// ball_engine_if: groups the per-tick move enable, the two paddle spans and
// the ball/score outputs of the Speed Pong ball engine.
//   master : system side (drives tick and paddle spans, observes ball/score)
//   slave  : ball_engine side
// Signals:
//   tick            one-cycle move enable, synchronous to the engine clock
//   p1_y1/p1_y2     left paddle top/bottom
//   p2_y1/p2_y2     right paddle top/bottom
//   ball_x/ball_y   ball left/top edge
//   point_p1/p2     one-cycle score pulses
//   speed           current step size in pixels per tick
interface ball_engine_if;
  logic       tick;
  logic [9:0] p1_y1;
  logic [9:0] p1_y2;
  logic [9:0] p2_y1;
  logic [9:0] p2_y2;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       point_p1;
  logic       point_p2;
  logic [3:0] speed;

  modport master (
    output tick, p1_y1, p1_y2, p2_y1, p2_y2,
    input  ball_x, ball_y, point_p1, point_p2, speed
  );

  modport slave (
    input  tick, p1_y1, p1_y2, p2_y1, p2_y2,
    output ball_x, ball_y, point_p1, point_p2, speed
  );
endinterface

// File: rtl/ball_engine.sv
// ball_engine: ball motion and collision responder for Speed Pong.
// Holds the ball at center for SERVE_TICKS ticks, then moves it each tick,
// bouncing off the top/bottom walls and paddle faces, emitting a one-cycle
// point pulse on a miss and speeding up every HITS_PER_SPEEDUP paddle hits.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    ball_engine_if.slave (tick, paddle spans in; ball, points, speed out)
// Optional feature: define BALL_ANGLE_EN to add a one-pixel vertical boost
// after hits near the top or bottom quarter of a paddle.
module ball_engine #(
  parameter int unsigned SCREEN_W         = 640,
  parameter int unsigned SCREEN_H         = 480,
  parameter int unsigned BALL_SIZE        = 10,
  parameter int unsigned P1_X             = 20,
  parameter int unsigned P2_X             = 620,
  parameter int unsigned SERVE_TICKS      = 60,
  parameter int unsigned HITS_PER_SPEEDUP = 4,
  parameter int unsigned MAX_SPEED        = 8
) (
  input  logic          clk,
  input  logic          reset,
  ball_engine_if.slave  bus
);

  typedef enum logic [1:0] {SERVE, PLAY, SCORE} state_t;

  localparam int unsigned SCW = (SERVE_TICKS > 2) ? $clog2(SERVE_TICKS) : 1;
  localparam int unsigned HCW = (HITS_PER_SPEEDUP > 2) ? $clog2(HITS_PER_SPEEDUP) : 1;

  localparam logic [10:0] W_W    = 11'(SCREEN_W);
  localparam logic [10:0] H_H    = 11'(SCREEN_H);
  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] HALF   = 11'(BALL_SIZE / 2);
  localparam logic [10:0] PX1    = 11'(P1_X);
  localparam logic [10:0] PX2    = 11'(P2_X);
  localparam logic [10:0] PX2L   = 11'(P2_X - BALL_SIZE);
  localparam logic [10:0] YMAX   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] CX     = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [10:0] CY     = 11'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [3:0]  MAXS   = 4'(MAX_SPEED);
  localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_TICKS - 1);
  localparam logic [HCW-1:0] HIT_LAST   = HCW'(HITS_PER_SPEEDUP - 1);

  state_t         state_q, state_d;
  logic [10:0]    bx_q, bx_d;
  logic [10:0]    by_q, by_d;
  logic           dx_q, dx_d;      // 1 = moving right
  logic           dy_q, dy_d;      // 1 = moving down
  logic [3:0]     spd_q, spd_d;
  logic [HCW-1:0] hit_q, hit_d;
  logic [SCW-1:0] serve_q, serve_d;
  logic           pp1_q, pp1_d;
  logic           pp2_q, pp2_d;
`ifdef BALL_ANGLE_EN
  logic           vb_q, vb_d;
  logic [10:0]    hy1, hy2, qtr, ctr;
  logic           boost;
`endif

  logic [10:0] s11, v, by_bot, bx_right, nx, ny;
  logic        ndx, ndy, ov1, ov2, hit, miss_l, miss_r;

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    spd_d   = spd_q;
    hit_d   = hit_q;
    serve_d = serve_q;
    pp1_d   = 1'b0;
    pp2_d   = 1'b0;

    s11 = {7'd0, spd_q};
`ifdef BALL_ANGLE_EN
    vb_d = vb_q;
    v    = s11 + {10'd0, vb_q};
`else
    v    = s11;
`endif
    by_bot   = by_q + BS;
    bx_right = bx_q + BS;

    // An empty or inverted paddle span never overlaps the ball.
    ov1 = (bus.p1_y1 < bus.p1_y2) && (by_bot > {1'b0, bus.p1_y1}) &&
          (by_q < {1'b0, bus.p1_y2});
    ov2 = (bus.p2_y1 < bus.p2_y2) && (by_bot > {1'b0, bus.p2_y1}) &&
          (by_q < {1'b0, bus.p2_y2});

    ny  = by_q;
    ndy = dy_q;
    if (dy_q) begin
      if (by_bot + v >= H_H) begin
        ny  = YMAX;
        ndy = 1'b0;
      end else begin
        ny = by_q + v;
      end
    end else begin
      if (by_q <= v) begin
        ny  = '0;
        ndy = 1'b1;
      end else begin
        ny = by_q - v;
      end
    end

    // Hit is tested before miss; a ball already behind a paddle just runs on.
    nx     = bx_q;
    ndx    = dx_q;
    hit    = 1'b0;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (dx_q) begin
      if ((bx_right < PX2) && (bx_right + s11 >= PX2) && ov2) begin
        nx  = PX2L;
        ndx = 1'b0;
        hit = 1'b1;
      end else if (bx_right + s11 >= W_W) begin
        miss_r = 1'b1;
      end else begin
        nx = bx_q + s11;
      end
    end else begin
      // bx_q - s <= P1_X written as bx_q <= P1_X + s to avoid underflow
      if ((bx_q > PX1) && (bx_q <= PX1 + s11) && ov1) begin
        nx  = PX1;
        ndx = 1'b1;
        hit = 1'b1;
      end else if (bx_q <= s11) begin
        miss_l = 1'b1;
      end else begin
        nx = bx_q - s11;
      end
    end

`ifdef BALL_ANGLE_EN
    hy1   = dx_q ? {1'b0, bus.p2_y1} : {1'b0, bus.p1_y1};
    hy2   = dx_q ? {1'b0, bus.p2_y2} : {1'b0, bus.p1_y2};
    qtr   = (hy2 - hy1) >> 2;
    ctr   = by_q + HALF;
    boost = (ctr < hy1 + qtr) || (ctr >= hy2 - qtr);
`endif

    unique case (state_q)
      SERVE: begin
        if (bus.tick) begin
          if (serve_q == SERVE_LAST) begin
            serve_d = '0;
            state_d = PLAY;
          end else begin
            serve_d = serve_q + SCW'(1);
          end
        end
      end
      PLAY: begin
        if (bus.tick) begin
          if (miss_l || miss_r) begin
            // Re-centre immediately so the pulse cycle already shows the serve position.
            state_d = SCORE;
            pp1_d   = miss_r;
            pp2_d   = miss_l;
            bx_d    = CX;
            by_d    = CY;
            spd_d   = 4'd1;
            hit_d   = '0;
            dx_d    = miss_r;
`ifdef BALL_ANGLE_EN
            vb_d    = 1'b0;
`endif
          end else begin
            bx_d = nx;
            by_d = ny;
            dx_d = ndx;
            dy_d = ndy;
            if (hit) begin
              if (hit_q == HIT_LAST) begin
                hit_d = '0;
                if (spd_q < MAXS) spd_d = spd_q + 4'd1;
              end else begin
                hit_d = hit_q + HCW'(1);
              end
`ifdef BALL_ANGLE_EN
              vb_d = boost;
`endif
            end
          end
        end
      end
      SCORE: begin
        state_d = SERVE;
        bx_d    = CX;
        by_d    = CY;
        spd_d   = 4'd1;
        hit_d   = '0;
        serve_d = '0;
`ifdef BALL_ANGLE_EN
        vb_d    = 1'b0;
`endif
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SERVE;
      bx_q    <= CX;
      by_q    <= CY;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      spd_q   <= 4'd1;
      hit_q   <= '0;
      serve_q <= '0;
      pp1_q   <= 1'b0;
      pp2_q   <= 1'b0;
`ifdef BALL_ANGLE_EN
      vb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      spd_q   <= spd_d;
      hit_q   <= hit_d;
      serve_q <= serve_d;
      pp1_q   <= pp1_d;
      pp2_q   <= pp2_d;
`ifdef BALL_ANGLE_EN
      vb_q    <= vb_d;
`endif
    end
  end

  // Positions never exceed 10 bits; the 11th bit only exists for the math.
  logic unused_hi;
  assign unused_hi = bx_q[10] ^ by_q[10];

  assign bus.ball_x   = bx_q[9:0];
  assign bus.ball_y   = by_q[9:0];
  assign bus.point_p1 = pp1_q;
  assign bus.point_p2 = pp2_q;
  assign bus.speed    = spd_q;

endmodule

// File: tb/tb_ball_engine.sv
module tb_ball_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ball_engine_if bus ();

  ball_engine #(
    .SCREEN_W(640), .SCREEN_H(480), .BALL_SIZE(10), .P1_X(20), .P2_X(620),
    .SERVE_TICKS(60), .HITS_PER_SPEEDUP(4), .MAX_SPEED(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x; int y; int s; int p1; int p2;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit t;
    int p1a; int p1b; int p2a; int p2b;
    int n;
    int ex; int ey; int es; int ep1; int ep2;
  } vec_t;
  vec_t tbl[13];

  // Reference model state: dx/dy are +1/-1, state 0=serve 1=play 2=score
  int mx, my, mdx, mdy, mspd, mhits, mserve, mst, mvb;
  int mp1, mp2, mhit_now, mhit_total;
  int p1a, p1b, p2a, p2b;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    mx = 315; my = 235; mdx = 1; mdy = 1; mspd = 1; mhits = 0;
    mserve = 0; mst = 0; mvb = 0; mp1 = 0; mp2 = 0; mhit_now = 0;
  endtask

  function automatic bit overlaps(input int a, input int b, input int y);
    return (a < b) && (y + 10 > a) && (y < b);
  endfunction

  task automatic model_step(input bit t);
    int v, ny, nx, ndy, ndx, a, b, c, q;
    bit hit, m1, m2;
    mhit_now = 0;
    if (mst == 2) begin
      mp1 = 0; mp2 = 0; mst = 0; mserve = 0;
      return;
    end
    mp1 = 0; mp2 = 0;
    if (!t) return;
    if (mst == 0) begin
      if (mserve == 59) begin mserve = 0; mst = 1; end
      else mserve++;
      return;
    end
    v = mspd;
`ifdef BALL_ANGLE_EN
    v = v + mvb;
`endif
    ndy = mdy;
    if (mdy < 0) begin
      ny = my - v;
      if (ny <= 0) begin ny = 0; ndy = 1; end
    end else begin
      ny = my + v;
      if (ny + 10 >= 480) begin ny = 470; ndy = -1; end
    end
    nx = mx + mdx * mspd; ndx = mdx; hit = 0; m1 = 0; m2 = 0;
    if (mdx < 0) begin
      if (mx > 20 && nx <= 20 && overlaps(p1a, p1b, my)) begin
        nx = 20; ndx = 1; hit = 1;
      end else if (nx <= 0) m2 = 1;
    end else begin
      if (mx + 10 < 620 && nx + 10 >= 620 && overlaps(p2a, p2b, my)) begin
        nx = 610; ndx = -1; hit = 1;
      end else if (nx + 10 >= 640) m1 = 1;
    end
    if (m1 || m2) begin
      mst = 2; mp1 = m1; mp2 = m2;
      mx = 315; my = 235; mspd = 1; mhits = 0; mvb = 0;
      mdx = m1 ? 1 : -1;
      return;
    end
    if (hit) begin
      mhit_now = 1;
      mhit_total++;
      a = (mdx > 0) ? p2a : p1a;
      b = (mdx > 0) ? p2b : p1b;
      q = (b - a) / 4;
      c = my + 5;
      mvb = (c < a + q || c >= b - q) ? 1 : 0;
      if (mhits == 3) begin
        mhits = 0;
        if (mspd < 8) mspd++;
      end else mhits++;
    end
    mx = nx; my = ny; mdx = ndx; mdy = ndy;
  endtask

  task automatic set_paddles(input int a1, input int b1, input int a2, input int b2);
    p1a = a1; p1b = b1; p2a = a2; p2b = b2;
    bus.p1_y1 = 10'(a1); bus.p1_y2 = 10'(b1);
    bus.p2_y1 = 10'(a2); bus.p2_y2 = 10'(b2);
  endtask

  task automatic run_cycle(input bit t);
    exp_t e, g;
    @(negedge clk);
    bus.tick = t;
    model_step(t);
    e = '{mx, my, mspd, mp1, mp2};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      g = sbq.pop_front();
      chk("sb_x", int'(bus.ball_x), g.x);
      chk("sb_y", int'(bus.ball_y), g.y);
      chk("sb_speed", int'(bus.speed), g.s);
      chk("sb_p1", int'(bus.point_p1), g.p1);
      chk("sb_p2", int'(bus.point_p2), g.p2);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_x"}, int'(bus.ball_x), 315);
    chk({tag, "_y"}, int'(bus.ball_y), 235);
    chk({tag, "_speed"}, int'(bus.speed), 1);
    chk({tag, "_p1"}, int'(bus.point_p1), 0);
    chk({tag, "_p2"}, int'(bus.point_p2), 0);
  endtask

  initial begin
    int cyc;
    tbl[0]  = '{1, 180, 300, 180, 300, 60,  315, 235, 1, 0, 0};
    tbl[1]  = '{1, 180, 300, 180, 300, 1,   316, 236, 1, 0, 0};
    tbl[2]  = '{0, 180, 300, 180, 300, 5,   316, 236, 1, 0, 0};
    tbl[3]  = '{1, 180, 300, 180, 300, 233, 549, 469, 1, 0, 0};
    tbl[4]  = '{1, 180, 300, 180, 300, 1,   550, 470, 1, 0, 0};
    tbl[5]  = '{1, 180, 300, 180, 300, 1,   551, 469, 1, 0, 0};
    tbl[6]  = '{1, 180, 300, 180, 300, 58,  609, 411, 1, 0, 0};
    tbl[7]  = '{1, 180, 300, 180, 300, 1,   610, 410, 1, 0, 0};
    tbl[8]  = '{1, 180, 300, 180, 300, 19,  629, 391, 1, 0, 0};
    tbl[9]  = '{1, 180, 300, 180, 300, 1,   315, 235, 1, 1, 0};
    tbl[10] = '{1, 180, 300, 180, 300, 1,   315, 235, 1, 0, 0};
    tbl[11] = '{1, 180, 300, 180, 300, 60,  315, 235, 1, 0, 0};
    tbl[12] = '{1, 180, 300, 180, 300, 1,   316, 234, 1, 0, 0};

    mhit_total = 0;
    reset = 1'b1;
    bus.tick = 1'b0;
    set_paddles(180, 300, 180, 300);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    // Table-driven serve, wall bounce, paddle pass-through and right miss
    foreach (tbl[i]) begin
      set_paddles(tbl[i].p1a, tbl[i].p1b, tbl[i].p2a, tbl[i].p2b);
      for (int k = 0; k < tbl[i].n; k++) run_cycle(tbl[i].t);
      chk($sformatf("vec%0d_x", i), int'(bus.ball_x), tbl[i].ex);
      chk($sformatf("vec%0d_y", i), int'(bus.ball_y), tbl[i].ey);
      chk($sformatf("vec%0d_speed", i), int'(bus.speed), tbl[i].es);
      chk($sformatf("vec%0d_p1", i), int'(bus.point_p1), tbl[i].ep1);
      chk($sformatf("vec%0d_p2", i), int'(bus.point_p2), tbl[i].ep2);
    end

    // Full-height paddles: rally until 32 hits, checking speed milestones
    @(negedge clk);
    reset = 1'b1;
    bus.tick = 1'b0;
    @(negedge clk);
    model_reset();
    mhit_total = 0;
    set_paddles(0, 479, 0, 479);
    reset = 1'b0;
    cyc = 0;
    while (mhit_total < 32 && cyc < 20000) begin
      run_cycle(1'b1);
      cyc++;
      if (mhit_now == 1) begin
        case (mhit_total)
          1: begin
            chk("first_hit_x", int'(bus.ball_x), 610);
            chk("first_hit_y", int'(bus.ball_y), 410);
            chk("first_hit_p1", int'(bus.point_p1), 0);
          end
          4:  chk("speed_after_4", int'(bus.speed), 2);
          8:  chk("speed_after_8", int'(bus.speed), 3);
          28: chk("speed_after_28", int'(bus.speed), 8);
          32: chk("speed_after_32", int'(bus.speed), 8);
          default: ;
        endcase
      end
    end
    checks++;
    if (mhit_total < 32) begin
      errors++;
      $display("FAIL rally_timeout: got %0d hits expected 32", mhit_total);
    end

    // Reset mid-flight during PLAY
    reset = 1'b1;
    #1;
    check_reset_vals("rst_play");
    bus.tick = 1'b0;
    @(negedge clk);
    model_reset();
    reset = 1'b0;

    // Reset during the SCORE cycle: right paddle too short to reach
    set_paddles(180, 300, 0, 20);
    cyc = 0;
    while (mst != 2 && cyc < 2000) begin
      run_cycle(1'b1);
      cyc++;
    end
    chk("score_pulse_seen", int'(bus.point_p1), 1);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_score");
    bus.tick = 1'b0;
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    repeat (60) run_cycle(1'b1);
    chk("reserve_hold_x", int'(bus.ball_x), 315);
    run_cycle(1'b1);
    chk("reserve_launch_x", int'(bus.ball_x), 316);
    chk("reserve_launch_y", int'(bus.ball_y), 236);
    chk("reserve_p1", int'(bus.point_p1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
